// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key gesture decoder: FSM state encodings used by
// the decoder, the LED/menu consumers and the bench.
package key_event_decoder_pkg;

  typedef logic [2:0] key_state_t;

  localparam key_state_t S_IDLE      = 3'd0;
  localparam key_state_t S_PRESS1    = 3'd1;
  localparam key_state_t S_LONG_HOLD = 3'd2;
  localparam key_state_t S_WAIT2     = 3'd3;
  localparam key_state_t S_PRESS2    = 3'd4;

endpackage

// File: rtl/key_event_decoder_ms_timebase.sv
// Millisecond prescaler: counts 0..MS_TICKS-1 and flags the last count as a tick.
// A synchronous clear restarts the millisecond so timeouts begin on a state change.
module ms_timebase #(
  parameter int MS_TICKS = 50000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Clr,
  output logic Ms_Tick
);

  localparam int PW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [PW-1:0] LAST = PW'(MS_TICKS - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc <= '0;
    end else if (Clr || (presc == LAST)) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign Ms_Tick = (presc == LAST);

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle click / double-click / long-press pulses,
// so downstream LED and menu logic needs no timing of its own.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int MS_TICKS   = 50000,
  parameter int LONG_MS    = 1000,
  parameter int DCLK_MS    = 300
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Key_In,
  output logic Click_Sig,
  output logic Double_Sig,
  output logic Long_Sig,
  output logic Busy
);

  localparam int CW = $clog2(LONG_MS + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] LONG_CNT = CW'(LONG_MS);
  localparam logic [CW-1:0] DCLK_CNT = CW'(DCLK_MS);

  generate
    if (MS_TICKS < 1) begin : g_bad_ms_ticks
      $error("key_event_decoder: MS_TICKS must be >= 1");
    end
    if (LONG_MS < 1) begin : g_bad_long_ms
      $error("key_event_decoder: LONG_MS must be >= 1");
    end
    if (DCLK_MS < 1) begin : g_bad_dclk_ms
      $error("key_event_decoder: DCLK_MS must be >= 1");
    end
    // The ms counter is sized by LONG_MS, so the double-click window must fit in it.
    if (DCLK_MS > (2 ** CW) - 1) begin : g_bad_dclk_width
      $error("key_event_decoder: DCLK_MS does not fit the ms counter");
    end
  endgenerate

  logic          key_q;
  logic          pressed;
  logic          ms_tick;
  logic          state_chg;
  logic [CW-1:0] ms_cnt;
  key_state_t    state;
  key_state_t    state_nxt;
  logic          click_nxt;
  logic          dbl_nxt;
  logic          long_nxt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      key_q <= ACTIVE_LOW;
    end else begin
      key_q <= Key_In;
    end
  end

  assign pressed   = (key_q == !ACTIVE_LOW);
  assign state_chg = (state_nxt != state);

  ms_timebase #(
    .MS_TICKS(MS_TICKS)
  ) u_timebase (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .Clr    (state_chg),
    .Ms_Tick(ms_tick)
  );

  // Elapsed ms in the current state; saturates instead of wrapping.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ms_cnt <= '0;
    end else if (state_chg) begin
      ms_cnt <= '0;
    end else if (ms_tick && (ms_cnt != CNT_MAX)) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    click_nxt = 1'b0;
    dbl_nxt   = 1'b0;
    long_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pressed) state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (!pressed) begin
          state_nxt = S_WAIT2;
        end else if (ms_cnt == LONG_CNT) begin
          long_nxt  = 1'b1;
          state_nxt = S_LONG_HOLD;
        end
      end
      S_LONG_HOLD: begin
        if (!pressed) state_nxt = S_IDLE;
      end
      S_WAIT2: begin
        // Timeout is tested first so a press landing on the boundary yields a click.
        if (ms_cnt == DCLK_CNT) begin
          click_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else if (pressed) begin
          state_nxt = S_PRESS2;
        end
      end
      S_PRESS2: begin
        if (!pressed) begin
          dbl_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= S_IDLE;
      Click_Sig  <= 1'b0;
      Double_Sig <= 1'b0;
      Long_Sig   <= 1'b0;
    end else begin
      state      <= state_nxt;
      Click_Sig  <= click_nxt;
      Double_Sig <= dbl_nxt;
      Long_Sig   <= long_nxt;
    end
  end

  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: an active-low and an active-high build see the
// same gestures (with inverted key levels) and must produce identical pulses.
module tb_key_event_decoder;

  localparam int MS_TICKS = 4;
  localparam int LONG_MS  = 10;
  localparam int DCLK_MS  = 5;
  // Cycles from a key drive to the pulse edge: key_q capture, state entry, ms count, output register.
  localparam int CLICK_LAT = DCLK_MS * MS_TICKS + 3;
  localparam int LONG_LAT  = LONG_MS * MS_TICKS + 3;
  localparam int DBL_LAT   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       held;
  logic       key_al;
  logic       key_ah;
  logic [1:0] click_o, dbl_o, long_o, busy_o;
  logic [1:0] click_q, dbl_q, long_q;

  int cycle = 0;
  int drive_cyc;
  int n_checks = 0;
  int n_pass = 0;
  int click_n[2], dbl_n[2], long_n[2];
  int click_first[2], dbl_first[2], long_first[2];
  int viol[2];

  assign key_al = ~held;
  assign key_ah = held;

  always #5 clk = ~clk;
  always @(posedge clk) cycle = cycle + 1;

  key_event_decoder #(
    .ACTIVE_LOW(1'b1), .MS_TICKS(MS_TICKS), .LONG_MS(LONG_MS), .DCLK_MS(DCLK_MS)
  ) dut_al (
    .CLK(clk), .RST_n(rst_n), .Key_In(key_al),
    .Click_Sig(click_o[0]), .Double_Sig(dbl_o[0]), .Long_Sig(long_o[0]), .Busy(busy_o[0])
  );

  key_event_decoder #(
    .ACTIVE_LOW(1'b0), .MS_TICKS(MS_TICKS), .LONG_MS(LONG_MS), .DCLK_MS(DCLK_MS)
  ) dut_ah (
    .CLK(clk), .RST_n(rst_n), .Key_In(key_ah),
    .Click_Sig(click_o[1]), .Double_Sig(dbl_o[1]), .Long_Sig(long_o[1]), .Busy(busy_o[1])
  );

  // Pulse recorder; also flags pulses wider than one cycle or overlapping pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ($countones({click_o[i], dbl_o[i], long_o[i]}) > 1) viol[i]++;
      if ((click_o[i] && click_q[i]) || (dbl_o[i] && dbl_q[i]) || (long_o[i] && long_q[i])) viol[i]++;
      if (click_o[i]) begin
        if (click_n[i] == 0) click_first[i] = cycle;
        click_n[i]++;
      end
      if (dbl_o[i]) begin
        if (dbl_n[i] == 0) dbl_first[i] = cycle;
        dbl_n[i]++;
      end
      if (long_o[i]) begin
        if (long_n[i] == 0) long_first[i] = cycle;
        long_n[i]++;
      end
    end
    click_q = click_o;
    dbl_q   = dbl_o;
    long_q  = long_o;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lvl, input int cycles);
    @(posedge clk);
    #1;
    held = lvl;
    drive_cyc = cycle;
    repeat (cycles - 1) @(posedge clk);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      click_n[i] = 0;      dbl_n[i] = 0;       long_n[i] = 0;
      click_first[i] = -1; dbl_first[i] = -1;  long_first[i] = -1;
    end
  endtask

  task automatic check_counts(input string name, input int c, input int d, input int l);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s.click_cnt[%0d]", name, i), click_n[i], c);
      checkOutput($sformatf("%s.double_cnt[%0d]", name, i), dbl_n[i], d);
      checkOutput($sformatf("%s.long_cnt[%0d]", name, i), long_n[i], l);
      checkOutput($sformatf("%s.busy[%0d]", name, i), int'(busy_o[i]), 0);
    end
  endtask

  task automatic check_quiet(input string name);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s.outputs[%0d]", name, i),
                  int'({click_o[i], dbl_o[i], long_o[i], busy_o[i]}), 0);
    end
  endtask

  int ref_cyc;

  initial begin
    held  = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) viol[i] = 0;
    click_q = '0; dbl_q = '0; long_q = '0;
    clear_counts();

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_quiet("post_reset");

    $display("[TB] single click");
    clear_counts();
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 40);
    ref_cyc = drive_cyc;
    check_counts("click", 1, 0, 0);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("click.latency[%0d]", i), click_first[i] - ref_cyc, CLICK_LAT);

    $display("[TB] double click");
    clear_counts();
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 40);
    ref_cyc = drive_cyc;
    check_counts("double", 0, 1, 0);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("double.latency[%0d]", i), dbl_first[i] - ref_cyc, DBL_LAT);

    $display("[TB] long press");
    clear_counts();
    applyStimulus(1'b1, 60);
    ref_cyc = drive_cyc;
    applyStimulus(1'b0, 40);
    check_counts("long", 0, 0, 1);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("long.latency[%0d]", i), long_first[i] - ref_cyc, LONG_LAT);

    $display("[TB] second press one cycle inside the window");
    clear_counts();
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, DCLK_MS * MS_TICKS);
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 40);
    check_counts("gap_inside", 0, 1, 0);

    $display("[TB] second press on the timeout boundary");
    clear_counts();
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, DCLK_MS * MS_TICKS + 1);
    ref_cyc = drive_cyc;
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 40);
    check_counts("gap_boundary", 2, 0, 0);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("gap_boundary.latency[%0d]", i), click_first[i] - ref_cyc, CLICK_LAT);

    $display("[TB] reset in the middle of the double-click window");
    clear_counts();
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 10);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_counts("mid_reset", 0, 0, 0);

    $display("[TB] key held through reset release");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    held  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_counts();
    rst_n = 1'b1;
    ref_cyc = cycle;
    repeat (60) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("held_reset.long_cnt[%0d]", i), long_n[i], 1);
      checkOutput($sformatf("held_reset.latency[%0d]", i), long_first[i] - ref_cyc, LONG_LAT);
    end
    applyStimulus(1'b0, 20);
    check_counts("held_reset", 0, 0, 1);

    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("pulse_shape[%0d]", i), viol[i], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
